// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : fetch PC + predictor lookup, single outstanding imem request,
//              FWFT fetch queue to decode. Optional FETCH_PERF_EN counters.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pred_pc,
    input  logic        pred_valid,
    input  logic        pred_taken,
    input  logic [31:0] pred_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_instr,
    output logic        dec_pred_taken,
    output logic [31:0] dec_pred_target,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects,
`endif
    input  logic        dec_ready
);

    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic        drop, drop_nxt;
    logic        req_fire;
    logic        push;
    logic        pop;
    logic        has_space;
    logic        taken;
    logic [31:0] next_pc;

    logic [31:0] pend_pc;
    logic        pend_taken;
    logic [31:0] pend_target;

    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [31:0]      fq_pc     [FQ_DEPTH];
    logic [31:0]      fq_instr  [FQ_DEPTH];
    logic             fq_taken  [FQ_DEPTH];
    logic [31:0]      fq_target [FQ_DEPTH];

    assign pred_pc       = fetch_pc;
    assign imem_req_addr = fetch_pc;

    assign taken   = pred_valid & pred_taken;
    assign next_pc = taken ? {pred_target[31:2], 2'b00} : fetch_pc + 32'd4;

    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready & ~redirect_valid;
    // A head leaving this cycle frees the slot the new request will need.
    assign has_space = (count < CNT_W'(FQ_DEPTH)) | pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            drop     <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        drop_nxt       = drop;
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        push           = 1'b0;
        case (state)
            S_REQ: begin
                imem_req_valid = rst_n & ~redirect_valid & has_space;
                req_fire       = imem_req_valid & imem_req_ready;
                if (req_fire) begin
                    fetch_pc_nxt = next_pc;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    push      = ~drop;
                    drop_nxt  = 1'b0;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
        // A redirect kills any response this cycle and marks a still-pending one stale.
        if (redirect_valid) begin
            fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
            push         = 1'b0;
            if (((state == S_WAIT) && !imem_resp_valid) || req_fire) begin
                drop_nxt  = 1'b1;
                state_nxt = S_WAIT;
            end else begin
                drop_nxt  = 1'b0;
                state_nxt = S_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_pc     <= '0;
            pend_taken  <= 1'b0;
            pend_target <= '0;
        end else if (req_fire) begin
            pend_pc     <= fetch_pc;
            pend_taken  <= taken;
            pend_target <= taken ? pred_target : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc[wr_ptr]     <= pend_pc;
            fq_instr[wr_ptr]  <= imem_resp_data;
            fq_taken[wr_ptr]  <= pend_taken;
            fq_target[wr_ptr] <= pend_target;
        end
    end

    assign dec_pc          = dec_valid ? fq_pc[rd_ptr]     : 32'h0;
    assign dec_instr       = dec_valid ? fq_instr[rd_ptr]  : 32'h0;
    assign dec_pred_taken  = dec_valid ? fq_taken[rd_ptr]  : 1'b0;
    assign dec_pred_target = dec_valid ? fq_target[rd_ptr] : 32'h0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (push)           perf_fetched   <= perf_fetched + 32'd1;
            if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the BTB/branch predictor and drives its prediction lookup. It holds the fetch PC, presents it to the predictor, and issues one instruction-memory request at a time. It selects the next PC from the predictor's combinational answer. Returned instructions, tagged with PC and prediction, go into a small fetch queue that feeds decode. Backend redirects (mispredict/exception) flush the queue and squash the in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
FQ_DEPTH, 4, fetch-queue entries; power of two, >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
redirect_valid  input  1  backend redirect; highest priority
redirect_pc  input  32  new fetch PC on redirect
pred_pc  output  32  current fetch PC, to predictor lookup
pred_valid  input  1  predictor BTB hit
pred_taken  input  1  predictor taken direction
pred_target  input  32  predicted target
imem_req_valid  output  1  memory request valid
imem_req_addr  output  32  request address, equal to pred_pc
imem_req_ready  input  1  memory accepts request
imem_resp_valid  input  1  response valid; always accepted, no backpressure
imem_resp_data  input  32  instruction word
dec_valid  output  1  queue head valid
dec_pc  output  32  head PC
dec_instr  output  32  head instruction
dec_pred_taken  output  1  head predicted taken
dec_pred_target  output  32  head predicted target, zero if not taken
dec_ready  input  1  decode accepts head

Behaviour:
- Reset (async):
  - fetch_pc=RESET_PC; FSM=REQ; queue empty (count=0, rd/wr ptr=0); drop flag=0.
  - Outputs: imem_req_valid=0 only while in reset; dec_valid=0; dec_* =0.
- pred_pc and imem_req_addr are fetch_pc, combinational. Predictor lookup therefore completes in the same cycle as the request.
- Taken decision: taken = pred_valid & pred_taken. next_pc = taken ? {pred_target[31:2],2'b00} : fetch_pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- FSM states: REQ, WAIT.
  - REQ: imem_req_valid = (count < FQ_DEPTH) and no redirect this cycle.
    - On handshake: latch {fetch_pc, taken, taken?target:0} into a pending register; fetch_pc <= next_pc; go to WAIT.
  - WAIT: imem_req_valid=0.
    - On imem_resp_valid with drop=0: push {pending, imem_resp_data}; go to REQ.
    - With drop=1: discard the response; clear drop; go to REQ.
- Space reservation: a request issues only when count < FQ_DEPTH, so the push never overflows. The count check must include an entry dequeued in the same cycle, not only freed entries.
- Queue: FIFO, first-word-fall-through. dec_valid = count!=0.
  - Pop on dec_valid & dec_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FQ_DEPTH.
- Redirect (any state):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; queue flushed (count=0, pointers=0, dec_valid=0 next cycle).
  - A pop in the same cycle is ignored.
  - If in WAIT with no response this cycle, or if a request handshake occurs this cycle: drop <= 1 and FSM=WAIT.
  - A response arriving in the redirect cycle is discarded. FSM=REQ unless a request handshake also occurred that cycle.
  - No new request is raised in the redirect cycle (imem_req_valid=0).
- Latency: fetch_pc presented at cycle N; response at N+k; dec_valid at N+k+1 (registered queue).
- Only one request is ever outstanding.

Optional Feature:
FETCH_PERF_EN. When defined, two 32-bit output ports are added:
- perf_fetched: increments on each non-dropped queue push.
- perf_redirects: increments on each redirect_valid cycle.
- Both reset to 0 and wrap on overflow.

When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, imem ready, resp 1 cycle later, pred_valid=0 -> requests to 0x0,0x4,0x8; dec_pc sequence 0x0,0x4,0x8 with dec_pred_taken=0.
- pred_valid=1, pred_taken=1, pred_target=0x100 at fetch_pc 0x8 -> next request addr 0x100; entry for 0x8 has dec_pred_taken=1, dec_pred_target=0x100.
- dec_ready=0, FQ_DEPTH=4 -> exactly 4 entries queued, imem_req_valid stays 0. One pop lets one more request issue; no overflow.
- Redirect to 0x200 while in WAIT; response 0xDEADBEEF arrives next cycle -> response dropped, dec_valid=0, next request addr 0x200.
- Redirect in the same cycle as a request handshake and a pop -> queue empty, stale response dropped, subsequent request addr = redirect_pc.
- fetch_pc 0xFFFF_FFFC, not taken -> next request addr 0x0000_0000; redirect_pc 0x203 -> request addr 0x200.
